// File: rtl/norm_pipe_if.sv
// Handshake and data bundle for the FP normalization stage.
// The upstream/bench side uses the master modport and the normalizer uses the slave modport.
interface norm_pipe_if #(
  parameter int FRAC_W = 75,
  parameter int EXP_W  = 10,
  parameter int MANT_W = 26
);
  logic              in_valid;
  logic              in_ready;
  logic              s_tmp;
  logic              final_m;
  logic              frac_h_s;
  logic [EXP_W-1:0]  exp_in;
  logic [FRAC_W-1:0] frac_in;
  logic              ftz_en;
  logic              out_valid;
  logic              out_ready;
  logic              s_out;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W:0]   frac_out;
  logic              zero_m;
  logic              denorm_m;

  modport master (
    output in_valid, s_tmp, final_m, frac_h_s, exp_in, frac_in, ftz_en, out_ready,
    input  in_ready, out_valid, s_out, exp_out, frac_out, zero_m, denorm_m
  );

  modport slave (
    input  in_valid, s_tmp, final_m, frac_h_s, exp_in, frac_in, ftz_en, out_ready,
    output in_ready, out_valid, s_out, exp_out, frac_out, zero_m, denorm_m
  );
endinterface

// File: rtl/norm_pipe.sv
// Three-stage normalizer between the FP add/mult core and the rounder: leading-zero count,
// left normalize, then denormal right shift (with sticky) or flush-to-zero.
module norm_pipe #(
  parameter int FRAC_W = 75,
  parameter int EXP_W  = 10,
  parameter int MANT_W = 26
) (
  input  logic      clk,
  input  logic      rst,
  norm_pipe_if.slave bus
);
  localparam int LZ_W = $clog2(FRAC_W + 1);
  localparam int E_W  = EXP_W + 1;
  localparam int SH_W = EXP_W + 2;
  localparam int LO_W = FRAC_W - MANT_W;
  localparam logic [SH_W-1:0] SH_SAT = SH_W'(FRAC_W);
  localparam logic [LZ_W-1:0] LZ_ALL = LZ_W'(FRAC_W);

  // Leading zeros from the MSB; an all-zero fraction yields FRAC_W.
  function automatic logic [LZ_W-1:0] lzc(input logic [FRAC_W-1:0] f);
    logic [LZ_W-1:0] n;
    logic            found;
    n     = LZ_ALL;
    found = 1'b0;
    for (int i = FRAC_W - 1; i >= 0; i--) begin
      if (!found && f[i]) begin
        n     = LZ_W'(FRAC_W - 1 - i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return n;
  endfunction

  logic              load1_s, load2_s, load3_s;

  logic              v1_q, v1_d;
  logic              s1_q, s1_d;
  logic [LZ_W-1:0]   lz1_q, lz1_d;
  logic [EXP_W-1:0]  exp1_q, exp1_d;
  logic [FRAC_W-1:0] frac1_q, frac1_d;
  logic              ftz1_q, ftz1_d;

  logic              v2_q, v2_d;
  logic              s2_q, s2_d;
  logic [FRAC_W-1:0] t1_q, t1_d;
  logic [E_W-1:0]    e2_q, e2_d;
  logic              zero2_q, zero2_d;
  logic              ftz2_q, ftz2_d;

  logic              out_valid_q, out_valid_d;
  logic              s_out_q, s_out_d;
  logic [EXP_W-1:0]  exp_out_q, exp_out_d;
  logic [MANT_W:0]   frac_out_q, frac_out_d;
  logic              zero_m_q, zero_m_d;
  logic              denorm_m_q, denorm_m_d;

  logic [SH_W-1:0]     sh_s, sh_sat_s;
  logic [2*FRAC_W-1:0] wide_s;
  logic                nonpos_s;
  logic [FRAC_W-1:0]   t2_s;
  logic                lost_s;
  logic [EXP_W-1:0]    res_exp_s;
  logic [MANT_W:0]     res_frac_s;
  logic                res_zero_s, res_denorm_s;

  // Ready chain runs backwards from the output; reset blocks any accept in its cycle.
  always_comb begin
    load3_s = ~out_valid_q | bus.out_ready;
    load2_s = ~v2_q | load3_s;
    load1_s = ~v1_q | load2_s;
  end

  assign bus.in_ready  = load1_s & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.s_out     = s_out_q;
  assign bus.exp_out   = exp_out_q;
  assign bus.frac_out  = frac_out_q;
  assign bus.zero_m    = zero_m_q;
  assign bus.denorm_m  = denorm_m_q;

  // Stage 1: resolve the sign and count leading zeros.
  always_comb begin
    v1_d    = v1_q;
    s1_d    = s1_q;
    lz1_d   = lz1_q;
    exp1_d  = exp1_q;
    frac1_d = frac1_q;
    ftz1_d  = ftz1_q;
    if (load1_s) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d    = bus.final_m ? bus.s_tmp : (bus.s_tmp ^ bus.frac_h_s);
        lz1_d   = lzc(bus.frac_in);
        exp1_d  = bus.exp_in;
        frac1_d = bus.frac_in;
        ftz1_d  = bus.ftz_en;
      end else begin
        s1_d = s1_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 2: left normalize and adjust the exponent at one extra bit of range.
  always_comb begin
    v2_d    = v2_q;
    s2_d    = s2_q;
    t1_d    = t1_q;
    e2_d    = e2_q;
    zero2_d = zero2_q;
    ftz2_d  = ftz2_q;
    if (load2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_d    = s1_q;
        t1_d    = frac1_q << lz1_q;
        e2_d    = {exp1_q[EXP_W-1], exp1_q} - E_W'(lz1_q);
        zero2_d = (lz1_q == LZ_ALL);
        ftz2_d  = ftz1_q;
      end else begin
        s2_d = s2_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  // Denormal shift: the low half of the double-width word collects every bit shifted out.
  always_comb begin
    sh_s = SH_W'(1) - {e2_q[E_W-1], e2_q};
    if (sh_s > SH_SAT) begin
      sh_sat_s = SH_SAT;
    end else begin
      sh_sat_s = sh_s;
    end
    wide_s   = {t1_q, {FRAC_W{1'b0}}} >> sh_sat_s;
    nonpos_s = e2_q[E_W-1] | (e2_q == E_W'(0));
  end

  // Stage 3 result selection: zero, flush, denormal or normal.
  always_comb begin
    t2_s         = t1_q;
    lost_s       = 1'b0;
    res_exp_s    = e2_q[EXP_W-1:0];
    res_zero_s   = 1'b0;
    res_denorm_s = 1'b0;
    if (zero2_q || (nonpos_s && ftz2_q)) begin
      t2_s       = '0;
      res_exp_s  = '0;
      res_zero_s = 1'b1;
    end else if (nonpos_s) begin
      t2_s         = wide_s[2*FRAC_W-1:FRAC_W];
      lost_s       = |wide_s[FRAC_W-1:0];
      res_exp_s    = '0;
      res_denorm_s = 1'b1;
    end else begin
      t2_s = t1_q;
    end
    res_frac_s = {t2_s[FRAC_W-1 -: MANT_W], (|t2_s[LO_W-1:0]) | lost_s};
  end

  // Output registers hold steady while the rounder stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    s_out_d     = s_out_q;
    exp_out_d   = exp_out_q;
    frac_out_d  = frac_out_q;
    zero_m_d    = zero_m_q;
    denorm_m_d  = denorm_m_q;
    if (load3_s) begin
      out_valid_d = v2_q;
      if (v2_q) begin
        s_out_d    = s2_q;
        exp_out_d  = res_exp_s;
        frac_out_d = res_frac_s;
        zero_m_d   = res_zero_s;
        denorm_m_d = res_denorm_s;
      end else begin
        s_out_d = s_out_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State update with synchronous reset that drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      s1_q        <= 1'b0;
      lz1_q       <= '0;
      exp1_q      <= '0;
      frac1_q     <= '0;
      ftz1_q      <= 1'b0;
      v2_q        <= 1'b0;
      s2_q        <= 1'b0;
      t1_q        <= '0;
      e2_q        <= '0;
      zero2_q     <= 1'b0;
      ftz2_q      <= 1'b0;
      out_valid_q <= 1'b0;
      s_out_q     <= 1'b0;
      exp_out_q   <= '0;
      frac_out_q  <= '0;
      zero_m_q    <= 1'b0;
      denorm_m_q  <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      s1_q        <= s1_d;
      lz1_q       <= lz1_d;
      exp1_q      <= exp1_d;
      frac1_q     <= frac1_d;
      ftz1_q      <= ftz1_d;
      v2_q        <= v2_d;
      s2_q        <= s2_d;
      t1_q        <= t1_d;
      e2_q        <= e2_d;
      zero2_q     <= zero2_d;
      ftz2_q      <= ftz2_d;
      out_valid_q <= out_valid_d;
      s_out_q     <= s_out_d;
      exp_out_q   <= exp_out_d;
      frac_out_q  <= frac_out_d;
      zero_m_q    <= zero_m_d;
      denorm_m_q  <= denorm_m_d;
    end
  end
endmodule

// File: tb/tb_norm_pipe.sv
// Directed bench for norm_pipe: a table of single-beat vectors plus stall and
// mid-stream reset sequences, all with hand-computed expectations.
module tb_norm_pipe;
  localparam int FRAC_W = 75;
  localparam int EXP_W  = 10;
  localparam int MANT_W = 26;
  localparam int NV     = 14;

  typedef struct {
    logic        s_tmp;
    logic        final_m;
    logic        frac_h_s;
    logic        ftz;
    logic [9:0]  ex;
    logic [74:0] frac;
    logic        s_o;
    logic [9:0]  e_o;
    logic [26:0] f_o;
    logic        z_o;
    logic        d_o;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs[NV];

  norm_pipe_if #(.FRAC_W(FRAC_W), .EXP_W(EXP_W), .MANT_W(MANT_W)) bus ();

  norm_pipe #(.FRAC_W(FRAC_W), .EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic fm, input logic fh, input logic fz,
                              input logic [9:0] ex, input logic [74:0] fr, input logic so,
                              input logic [9:0] eo, input logic [26:0] fo, input logic zo,
                              input logic dd);
    vec_t v;
    v.s_tmp = st; v.final_m = fm; v.frac_h_s = fh; v.ftz = fz; v.ex = ex; v.frac = fr;
    v.s_o = so; v.e_o = eo; v.f_o = fo; v.z_o = zo; v.d_o = dd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.s_tmp    = v.s_tmp;
    bus.final_m  = v.final_m;
    bus.frac_h_s = v.frac_h_s;
    bus.ftz_en   = v.ftz;
    bus.exp_in   = v.ex;
    bus.frac_in  = v.frac;
  endtask

  // One beat through an idle pipe with the output always ready.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 80'(lat), 80'(3));
    chk({tag, "_s"},      80'(bus.s_out),    80'(v.s_o));
    chk({tag, "_exp"},    80'(bus.exp_out),  80'(v.e_o));
    chk({tag, "_frac"},   80'(bus.frac_out), 80'(v.f_o));
    chk({tag, "_zero"},   80'(bus.zero_m),   80'(v.z_o));
    chk({tag, "_denorm"}, 80'(bus.denorm_m), 80'(v.d_o));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [74:0] one;
    logic [74:0] ones;
    vec_t        b;
    int          acc, got, extra;
    logic        acc_now, emit_now, held_seen, stable;
    logic [9:0]  held_exp;
    logic [26:0] held_frac;

    n_tests = 0;
    n_fail  = 0;
    one  = 75'd1;
    ones = ~75'd0;
    //            st    fm    fh    ftz   exp       frac                          s     exp_o    frac_o          z     d
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd100,  one << 74,                    1'b0, 10'd100, 27'h4000000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd100,  one << 70,                    1'b0, 10'd96,  27'h4000000, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd100,  (one << 74) | one,            1'b0, 10'd100, 27'h4000001, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd2,    one << 70,                    1'b0, 10'd0,   27'h0800000, 1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 10'd2,    one << 70,                    1'b0, 10'd0,   27'h0000000, 1'b1, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 10'd55,   75'd0,                        1'b0, 10'd0,   27'h0000000, 1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd1,    one << 74,                    1'b1, 10'd1,   27'h4000000, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd0,    one << 74,                    1'b0, 10'd0,   27'h2000000, 1'b0, 1'b1);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'h338,  one << 74,                    1'b0, 10'd0,   27'h0000001, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd10,   ones,                         1'b0, 10'd10,  27'h7ffffff, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd100,  one,                          1'b0, 10'd26,  27'h4000000, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'd10,   one,                          1'b0, 10'd0,   27'h0000001, 1'b0, 1'b1);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd7,    75'd0,                        1'b1, 10'd0,   27'h0000000, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 1'b1, 1'b0, 10'd30,   (one << 51) | (one << 50),    1'b0, 10'd7,   27'h6000000, 1'b0, 1'b0);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 80'(bus.out_valid), 80'(0));
    chk("rst_in_ready",  80'(bus.in_ready),  80'(1));
    chk("rst_exp_out",   80'(bus.exp_out),   80'(0));
    chk("rst_frac_out",  80'(bus.frac_out),  80'(0));
    chk("rst_flags",     80'({bus.zero_m, bus.denorm_m, bus.s_out}), 80'(0));

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Stall: six beats offered back to back, output blocked for the first 8 cycles.
    acc = 0; got = 0; held_seen = 1'b0; stable = 1'b1;
    held_exp = '0; held_frac = '0;
    b = vecs[0];
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      bus.out_ready = (cyc >= 8);
      if (acc < 6) begin
        b.ex = 10'(20 + acc);
        drive(b);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      acc_now  = bus.in_valid & bus.in_ready;
      emit_now = bus.out_valid & bus.out_ready;
      if (bus.out_valid && !bus.out_ready) begin
        if (!held_seen) begin
          held_seen = 1'b1;
          held_exp  = bus.exp_out;
          held_frac = bus.frac_out;
        end else if (bus.exp_out !== held_exp || bus.frac_out !== held_frac) begin
          stable = 1'b0;
        end
      end
      if (cyc == 7) begin
        chk("stall_accepts",  80'(acc),          80'(3));
        chk("stall_in_ready", 80'(bus.in_ready), 80'(0));
        chk("stall_held",     80'({held_seen, stable}), 80'(3));
        chk("stall_head_exp", 80'(held_exp),     80'(20));
      end
      if (emit_now) begin
        chk($sformatf("drain_exp_%0d", got), 80'(bus.exp_out), 80'(20 + got));
        chk($sformatf("drain_frac_%0d", got), 80'(bus.frac_out), 80'(27'h4000000));
        got++;
      end
      @(posedge clk); #1;
      if (acc_now) acc++;
    end
    bus.in_valid = 1'b0;
    chk("drain_count", 80'(got), 80'(6));
    extra = 0;
    repeat (4) begin
      #1;
      if (bus.out_valid) extra++;
      @(posedge clk); #1;
    end
    chk("drain_no_dup", 80'(extra), 80'(0));

    // Mid-stream reset with three beats held in the pipe.
    bus.out_ready = 1'b0;
    b = vecs[0];
    for (int k = 0; k < 3; k++) begin
      b.ex = 10'(40 + k);
      drive(b);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("prerst_out_valid", 80'(bus.out_valid), 80'(1));
    b.ex = 10'd43;
    drive(b);
    rst = 1'b1;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", 80'(bus.out_valid), 80'(0));
    chk("midrst_in_ready",  80'(bus.in_ready),  80'(1));
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid) extra++;
    end
    chk("midrst_flushed", 80'(extra), 80'(0));
    run_vec(vecs[3], "post_rst_a");
    run_vec(vecs[13], "post_rst_b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
